iomem_rr_arbiter: RTL

- Two-requester round-robin arbiter that shares the picosoc iomem slave bus between two masters.
- Master 0 is the picosoc iomem port; master 1 is a secondary master such as a DMA or test injector.
- Serialises requests onto one downstream iomem port, returns read data and ready to the owning master, and keeps strict one-outstanding ordering.
- Sits between the SoC iomem pins and the peripheral decode fabric.

---
 rtl/iomem_rr_arbiter_if.sv | 26 ++
 rtl/iomem_rr_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iomem_rr_arbiter_if.sv
// rtl/iomem_rr_arbiter_if.sv - picorv32 mem-style iomem request/response bundle
//
// One request channel (valid/addr/wdata/wstrb) and its completion (ready/rdata).
// wstrb == 0 marks a read.
//   master modport : the side that issues requests
//   slave  modport : the side that completes them
interface iomem_rr_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              ready;
    logic [31:0]       rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/iomem_rr_arbiter.sv
// rtl/iomem_rr_arbiter.sv - two-master round-robin arbiter onto one iomem port
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   m0 (slave)    picosoc iomem master
//   m1 (slave)    secondary master (DMA / test injector)
//   s  (master)   downstream iomem port to the peripheral fabric
//   busy          high while a transaction is in BUSY or RESP
//   owner         index of the granted master, held through IDLE
//   timeout_err   one-cycle watchdog completion pulse
// Optional: IOMEM_RR_ARBITER_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES.
module iomem_rr_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               resetn,
    iomem_rr_arbiter_if.slave  m0,
    iomem_rr_arbiter_if.slave  m1,
    iomem_rr_arbiter_if.master s,
    output logic               busy,
    output logic               owner,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              last_grant;
    logic              do_grant;
    logic              grant_idx;
    logic              to_fire;
    logic              capture;
    logic [31:0]       cap_data;
    logic [31:0]       rdata0, rdata1;
    logic [ADDR_W-1:0] sel_addr;

`ifdef IOMEM_RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt;
    logic             to_err_q;

    // to_cnt holds the number of BUSY cycles already spent with s.ready low;
    // the watchdog fires on the cycle that would exceed the limit, unless
    // s.ready shows up on that very cycle.
    assign to_fire     = (state == BUSY) && !s.ready && (to_cnt == CNT_LIMIT);
    assign timeout_err = to_err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= to_fire;
            if (do_grant) begin
                to_cnt <= '0;
            end else if (state == BUSY && !s.ready && !to_fire) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign capture  = (state == BUSY) && (s.ready || to_fire);
    assign cap_data = s.ready ? s.rdata : 32'hDEAD_BEEF;

    // State register and per-transaction bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state <= state_nx;
            if (do_grant) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
            // Only the owner's read register ever moves.
            if (capture) begin
                if (owner) begin
                    rdata1 <= cap_data;
                end else begin
                    rdata0 <= cap_data;
                end
            end
        end
    end

    // Next-state and arbitration decision.
    always_comb begin
        state_nx  = state;
        do_grant  = 1'b0;
        grant_idx = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    do_grant = 1'b1;
                    // On a tie the master that did not win last time goes.
                    grant_idx = (m0.valid && m1.valid) ? ~last_grant : m1.valid;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                if (capture) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sel_addr = owner ? m1.addr : m0.addr;

    // Outputs decoded from state and owner.
    always_comb begin
        s.valid  = 1'b0;
        s.addr   = '0;
        s.wdata  = '0;
        s.wstrb  = '0;
        m0.ready = 1'b0;
        m1.ready = 1'b0;
        busy     = (state != IDLE);
        if (state == BUSY) begin
            s.valid = 1'b1;
            s.addr  = sel_addr;
            s.wdata = owner ? m1.wdata : m0.wdata;
            s.wstrb = owner ? m1.wstrb : m0.wstrb;
        end
        if (state == RESP) begin
            m0.ready = ~owner;
            m1.ready = owner;
        end
    end

    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;

endmodule
